// File: rtl/emsx_hps_io.sv
// Host-link command decoder: frames HPS_BUS transactions, writes core-facing
// registers and returns read data. Define HPS_RTC_EN to decode RTC command 0x22.
module emsx_hps_io #(
    parameter int STRLEN = 1
) (
    input  logic                clk_sys,
    input  logic                reset,
    inout  wire  [45:0]         HPS_BUS,
    input  logic [8*STRLEN-1:0] conf_str,
    input  logic                ioctl_wait,
    input  logic [2:0]          ps2_kbd_led_use,
    input  logic [2:0]          ps2_kbd_led_status,
    input  logic [7:0]          sd_buff_din,
    output logic [15:0]         joystick_0,
    output logic [15:0]         joystick_1,
    output logic [1:0]          buttons,
    output logic                forced_scandoubler,
    output logic [31:0]         status,
    output logic [64:0]         RTC,
    output logic [10:0]         ps2_key,
    output logic [24:0]         ps2_mouse,
    output logic [31:0]         sd_lba,
    output logic                sd_rd,
    output logic                sd_wr,
    output logic                sd_ack,
    output logic                sd_ack_conf,
    output logic [8:0]          sd_buff_addr,
    output logic [7:0]          sd_buff_dout,
    output logic                sd_buff_wr,
    output logic                img_mounted,
    output logic                img_readonly,
    output logic [63:0]         img_size
);

    typedef enum logic [1:0] {ST_WAIT, ST_IDLE, ST_CMD, ST_DATA} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  cmd_reg;
    logic [15:0] word_cnt_reg;
    logic [15:0] io_dout_reg;
    logic        buff_adv_reg;
    logic        cmd_strobe, data_strobe, txn_end;
    logic [7:0]  rd_cmd;
    logic [15:0] rd_idx, rd_value;
    logic [7:0]  conf_bytes [STRLEN];

    wire         io_strobe = HPS_BUS[33];
    wire         io_enable = HPS_BUS[34];
    wire  [15:0] io_din    = HPS_BUS[31:16];

    assign HPS_BUS[15:0]  = io_dout_reg;
    assign HPS_BUS[32]    = 1'b1;
    assign HPS_BUS[35]    = 1'bz;
    assign HPS_BUS[36]    = clk_sys;
    assign HPS_BUS[37]    = ioctl_wait;
    assign HPS_BUS[45:38] = 8'bzzzz_zzzz;

    // SD request outputs are held at 0; sd_ack_conf is tied low.
    assign sd_lba      = '0;
    assign sd_rd       = 1'b0;
    assign sd_wr       = 1'b0;
    assign sd_ack_conf = 1'b0;

    generate
        for (genvar gi = 0; gi < STRLEN; gi++) begin : g_conf
            assign conf_bytes[gi] = conf_str[8*(STRLEN-1-gi) +: 8];
        end
    endgenerate

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state_reg <= ST_WAIT;
        else       state_reg <= state_next;
    end

    // ST_WAIT holds off decoding until io_enable has been seen low after reset.
    always_comb begin
        state_next  = state_reg;
        cmd_strobe  = 1'b0;
        data_strobe = 1'b0;
        txn_end     = 1'b0;
        case (state_reg)
            ST_WAIT: if (!io_enable) state_next = ST_IDLE;
            ST_IDLE, ST_CMD: begin
                if (!io_enable) begin
                    state_next = ST_IDLE;
                end else if (io_strobe) begin
                    state_next = ST_DATA;
                    cmd_strobe = 1'b1;
                end else begin
                    state_next = ST_CMD;
                end
            end
            ST_DATA: begin
                if (!io_enable) begin
                    state_next = ST_IDLE;
                    txn_end    = 1'b1;
                end else begin
                    data_strobe = io_strobe;
                end
            end
            default: state_next = ST_WAIT;
        endcase
    end

    // Read data for the word that follows the current strobe.
    always_comb begin
        rd_cmd   = cmd_strobe ? io_din[7:0] : cmd_reg;
        rd_idx   = cmd_strobe ? 16'd0 : word_cnt_reg + 16'd1;
        rd_value = '0;
        case (rd_cmd)
            8'h14: begin
                for (int i = 0; i < STRLEN; i++)
                    if (rd_idx == 16'(i)) rd_value = {8'h00, conf_bytes[i]};
            end
            8'h16: begin
                case (rd_idx)
                    16'd0:   rd_value = {14'b0, sd_wr, sd_rd};
                    16'd1:   rd_value = sd_lba[15:0];
                    16'd2:   rd_value = sd_lba[31:16];
                    default: rd_value = '0;
                endcase
            end
            8'h18:   rd_value = {8'h00, sd_buff_din};
            8'h1F:   rd_value = {10'b0, ps2_kbd_led_use, ps2_kbd_led_status};
            default: rd_value = '0;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cmd_reg            <= '0;
            word_cnt_reg       <= '0;
            io_dout_reg        <= '0;
            buff_adv_reg       <= 1'b0;
            joystick_0         <= '0;
            joystick_1         <= '0;
            buttons            <= '0;
            forced_scandoubler <= 1'b0;
            status             <= '0;
            ps2_key            <= '0;
            ps2_mouse          <= '0;
            sd_ack             <= 1'b0;
            sd_buff_addr       <= '0;
            sd_buff_dout       <= '0;
            sd_buff_wr         <= 1'b0;
            img_mounted        <= 1'b0;
            img_readonly       <= 1'b0;
            img_size           <= '0;
        end else begin
            sd_buff_wr   <= 1'b0;
            buff_adv_reg <= 1'b0;
            img_mounted  <= txn_end && (cmd_reg == 8'h1C);
            // Advance after the write pulse so the pulse sees the pre-increment address.
            if (buff_adv_reg) sd_buff_addr <= sd_buff_addr + 9'd1;

            if (!io_enable) begin
                word_cnt_reg <= '0;
                io_dout_reg  <= '0;
                sd_ack       <= 1'b0;
            end else if (cmd_strobe) begin
                cmd_reg      <= io_din[7:0];
                word_cnt_reg <= '0;
                io_dout_reg  <= rd_value;
                sd_ack       <= (io_din[7:0] == 8'h17) || (io_din[7:0] == 8'h18);
                sd_buff_addr <= '0;
            end else if (data_strobe) begin
                word_cnt_reg <= word_cnt_reg + 16'd1;
                io_dout_reg  <= rd_value;
                case (cmd_reg)
                    8'h01: if (word_cnt_reg == 16'd0) begin
                        buttons            <= io_din[1:0];
                        forced_scandoubler <= io_din[4];
                    end
                    8'h02: if (word_cnt_reg == 16'd0) joystick_0 <= io_din;
                    8'h03: if (word_cnt_reg == 16'd0) joystick_1 <= io_din;
                    8'h04: case (word_cnt_reg)
                        16'd0: ps2_mouse[23:16] <= io_din[7:0];
                        16'd1: ps2_mouse[15:8]  <= io_din[7:0];
                        16'd2: begin
                            ps2_mouse[7:0] <= io_din[7:0];
                            ps2_mouse[24]  <= ~ps2_mouse[24];
                        end
                        default: ;
                    endcase
                    8'h05: if (word_cnt_reg == 16'd0) begin
                        ps2_key[9:0] <= io_din[9:0];
                        ps2_key[10]  <= ~ps2_key[10];
                    end
                    8'h1E: begin
                        if (word_cnt_reg == 16'd0) status[15:0]  <= io_din;
                        if (word_cnt_reg == 16'd1) status[31:16] <= io_din;
                    end
                    8'h17: begin
                        sd_buff_dout <= io_din[7:0];
                        sd_buff_wr   <= 1'b1;
                        buff_adv_reg <= 1'b1;
                    end
                    8'h18: buff_adv_reg <= 1'b1;
                    8'h1C: case (word_cnt_reg)
                        16'd0: img_readonly     <= io_din[0];
                        16'd1: img_size[15:0]   <= io_din;
                        16'd2: img_size[31:16]  <= io_din;
                        16'd3: img_size[47:32]  <= io_din;
                        16'd4: img_size[63:48]  <= io_din;
                        default: ;
                    endcase
                    default: ;
                endcase
            end
        end
    end

`ifdef HPS_RTC_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            RTC <= '0;
        end else if (data_strobe && cmd_reg == 8'h22) begin
            case (word_cnt_reg)
                16'd0: RTC[15:0]  <= io_din;
                16'd1: RTC[31:16] <= io_din;
                16'd2: RTC[47:32] <= io_din;
                16'd3: begin
                    RTC[63:48] <= io_din;
                    RTC[64]    <= ~RTC[64];
                end
                default: ;
            endcase
        end
    end
`else
    assign RTC = '0;
`endif

endmodule

// File: tb/tb_emsx_hps_io.sv
// Directed bench for emsx_hps_io: vector table for register writes plus
// sequences for reads, SD block transfer, mount pulse and async reset.
module tb_emsx_hps_io;
    localparam int STRLEN = 4;
    localparam int K_BTN = 0, K_FSD = 1, K_JOY0 = 2, K_JOY1 = 3,
                   K_STATUS = 4, K_MOUSE = 5, K_KEY = 6, K_RTC = 7;

    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    always #5 clk_sys = ~clk_sys;

    wire  [45:0] hps_bus;
    logic        io_strobe = 1'b0;
    logic        io_enable = 1'b0;
    logic [15:0] io_din = '0;
    assign hps_bus[31:16] = io_din;
    assign hps_bus[33]    = io_strobe;
    assign hps_bus[34]    = io_enable;

    logic [8*STRLEN-1:0] conf_str = 32'h4D53583B;
    logic        ioctl_wait = 1'b0;
    logic [2:0]  led_use = '0, led_status = '0;
    logic [7:0]  sd_buff_din = 8'h00;
    logic [15:0] joystick_0, joystick_1;
    logic [1:0]  buttons;
    logic        forced_scandoubler;
    logic [31:0] status;
    logic [64:0] RTC;
    logic [10:0] ps2_key;
    logic [24:0] ps2_mouse;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack, sd_ack_conf;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr, img_mounted, img_readonly;
    logic [63:0] img_size;

    emsx_hps_io #(.STRLEN(STRLEN)) dut (
        .clk_sys(clk_sys), .reset(reset), .HPS_BUS(hps_bus), .conf_str(conf_str),
        .ioctl_wait(ioctl_wait), .ps2_kbd_led_use(led_use),
        .ps2_kbd_led_status(led_status), .sd_buff_din(sd_buff_din),
        .joystick_0(joystick_0), .joystick_1(joystick_1), .buttons(buttons),
        .forced_scandoubler(forced_scandoubler), .status(status), .RTC(RTC),
        .ps2_key(ps2_key), .ps2_mouse(ps2_mouse), .sd_lba(sd_lba), .sd_rd(sd_rd),
        .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_ack_conf(sd_ack_conf),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .img_mounted(img_mounted),
        .img_readonly(img_readonly), .img_size(img_size)
    );

    int checks = 0;
    int failures = 0;

    // Buffer-write and mount-pulse monitor, sampled mid-cycle.
    int mon_wr_cnt = 0, mon_bad = 0, mon_mount = 0;
    always @(negedge clk_sys) begin
        if (sd_buff_wr) begin
            if (sd_buff_dout !== mon_wr_cnt[7:0] || sd_buff_addr !== mon_wr_cnt[8:0])
                mon_bad++;
            mon_wr_cnt++;
        end
        if (img_mounted) mon_mount++;
    end

    typedef struct {
        logic [7:0]       cmd;
        int               nw;
        logic [4:0][15:0] w;
        int               kind;
        logic [64:0]      exp;
    } vec_t;
    vec_t vecs[$];
    string knames[8] = '{"buttons", "forced_sd", "joystick_0", "joystick_1",
                         "status", "ps2_mouse", "ps2_key", "rtc"};

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic add_vec(input logic [7:0] cmd, input int nw, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] w3, input int kind, input logic [64:0] exp);
        vec_t v;
        v.cmd = cmd; v.nw = nw; v.w = {16'h0, w3, w2, w1, w0};
        v.kind = kind; v.exp = exp;
        vecs.push_back(v);
    endtask

    function automatic logic [64:0] observe(input int kind);
        case (kind)
            K_BTN:    return 65'(buttons);
            K_FSD:    return 65'(forced_scandoubler);
            K_JOY0:   return 65'(joystick_0);
            K_JOY1:   return 65'(joystick_1);
            K_STATUS: return 65'(status);
            K_MOUSE:  return 65'(ps2_mouse);
            K_KEY:    return 65'(ps2_key);
            default:  return RTC;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_word(input logic [15:0] w);
        io_din = w; io_strobe = 1'b1;
        @(negedge clk_sys);
        io_strobe = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic begin_txn(input logic [7:0] cmd);
        io_enable = 1'b1;
        @(negedge clk_sys);
        send_word({8'h00, cmd});
    endtask

    task automatic end_txn;
        io_enable = 1'b0;
        tick(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, ack_low;
        logic [7:0] conf_exp [5];
        conf_exp = '{8'h4D, 8'h53, 8'h58, 8'h3B, 8'h00};

        add_vec(8'h01, 1, 16'h0012, 0, 0, 0, K_BTN, 65'd2);
        add_vec(8'h01, 1, 16'h0010, 0, 0, 0, K_FSD, 65'd1);
        add_vec(8'h02, 1, 16'hA55A, 0, 0, 0, K_JOY0, 65'hA55A);
        add_vec(8'h03, 1, 16'h1234, 0, 0, 0, K_JOY1, 65'h1234);
        add_vec(8'h03, 1, 16'h00FF, 0, 0, 0, K_JOY0, 65'hA55A);
        add_vec(8'h1E, 2, 16'h0400, 16'h0003, 0, 0, K_STATUS, 65'h0003_0400);
        add_vec(8'h1E, 1, 16'hBEEF, 0, 0, 0, K_STATUS, 65'h0003_BEEF);
        add_vec(8'h04, 3, 16'h0011, 16'h0022, 16'h0033, 0, K_MOUSE, 65'h111_2233);
        add_vec(8'h04, 2, 16'h0044, 16'h0055, 0, 0, K_MOUSE, 65'h144_5533);
        add_vec(8'h05, 1, 16'h021C, 0, 0, 0, K_KEY, 65'h61C);
        add_vec(8'h05, 1, 16'h021C, 0, 0, 0, K_KEY, 65'h21C);
        add_vec(8'h99, 1, 16'hFFFF, 0, 0, 0, K_JOY0, 65'hA55A);
`ifdef HPS_RTC_EN
        add_vec(8'h22, 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, K_RTC, 65'h1_4444_3333_2222_1111);
`else
        add_vec(8'h22, 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, K_RTC, 65'd0);
`endif

        // Reset state
        tick(3);
        check("rst_joystick_0", 65'(joystick_0), 65'd0);
        check("rst_status", 65'(status), 65'd0);
        check("rst_ps2_key", 65'(ps2_key), 65'd0);
        check("rst_io_dout", 65'(hps_bus[15:0]), 65'd0);
        check("rst_sd_buff_addr", 65'(sd_buff_addr), 65'd0);
        check("io_wide", 65'(hps_bus[32]), 65'd1);
        reset = 1'b0;
        tick(2);
        ioctl_wait = 1'b1; #1;
        check("ioctl_wait_fwd", 65'(hps_bus[37]), 65'd1);
        ioctl_wait = 1'b0; #1;
        check("ioctl_wait_fwd0", 65'(hps_bus[37]), 65'd0);
        @(negedge clk_sys);

        foreach (vecs[i]) begin
            begin_txn(vecs[i].cmd);
            for (int j = 0; j < vecs[i].nw; j++) send_word(vecs[i].w[j]);
            end_txn();
            check(knames[vecs[i].kind], observe(vecs[i].kind), vecs[i].exp);
        end

        // LED read-back
        led_use = 3'b101; led_status = 3'b011;
        begin_txn(8'h1F);
        check("led_read", 65'(hps_bus[15:0]), 65'h002B);
        end_txn();
        check("dout_idle", 65'(hps_bus[15:0]), 65'd0);

        // Configuration string
        begin_txn(8'h14);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("conf_byte%0d", i), 65'(hps_bus[15:0]), 65'(conf_exp[i]));
            send_word(16'h0000);
        end
        end_txn();

        // SD block write into the core buffer
        base = mon_wr_cnt; ack_low = 0;
        begin_txn(8'h17);
        check("sd_ack_start", 65'(sd_ack), 65'd1);
        for (int i = 0; i < 512; i++) begin
            send_word(16'(i & 8'hFF));
            if (sd_ack !== 1'b1) ack_low++;
        end
        check("sd_wr_pulses", 65'(mon_wr_cnt - base), 65'd512);
        check("sd_wr_data_addr", 65'(mon_bad), 65'd0);
        check("sd_addr_wrap", 65'(sd_buff_addr), 65'd0);
        check("sd_ack_held", 65'(ack_low), 65'd0);
        end_txn();
        check("sd_ack_end", 65'(sd_ack), 65'd0);

        // Image mount
        base = mon_mount;
        begin_txn(8'h1C);
        send_word(16'h0001); send_word(16'h0000); send_word(16'h0040);
        send_word(16'h0000); send_word(16'h0000);
        check("mount_no_early_pulse", 65'(mon_mount - base), 65'd0);
        end_txn();
        tick(3);
        check("img_mounted_pulses", 65'(mon_mount - base), 65'd1);
        check("img_readonly", 65'(img_readonly), 65'd1);
        check("img_size", 65'(img_size), 65'h0000_0000_0040_0000);

        // Asynchronous reset mid-transaction, then wait for a fresh io_enable rise
        begin_txn(8'h02);
        check("dout_nonread", 65'(hps_bus[15:0]), 65'd0);
        send_word(16'h0031);
        check("joy0_before_reset", 65'(joystick_0), 65'h31);
        #2 reset = 1'b1;
        #1 check("async_reset", 65'(joystick_0), 65'd0);
        @(negedge clk_sys);
        tick(1);
        reset = 1'b0;
        tick(1);
        send_word(16'h0002);
        send_word(16'h00FF);
        check("wait_enable_rise", 65'(joystick_0), 65'd0);
        end_txn();
        begin_txn(8'h02);
        send_word(16'h0077);
        end_txn();
        check("joy0_after_rise", 65'(joystick_0), 65'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
